// File: rtl/sha1_pkg.sv
// Shared SHA-1 types, constants and round helpers for the round controller.
package sha1_pkg;

  typedef logic [31:0] word_t;

  localparam word_t H0_INIT = 32'h67452301;
  localparam word_t H1_INIT = 32'hEFCDAB89;
  localparam word_t H2_INIT = 32'h98BADCFE;
  localparam word_t H3_INIT = 32'h10325476;
  localparam word_t H4_INIT = 32'hC3D2E1F0;

  localparam word_t K0 = 32'h5A827999;
  localparam word_t K1 = 32'h6ED9EBA1;
  localparam word_t K2 = 32'h8F1BBCDC;
  localparam word_t K3 = 32'hCA62C1D6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUND  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } sha1_state_e;

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic word_t sha1_f(input logic [6:0] t, input word_t b, input word_t c,
                                   input word_t d);
    if (t < 7'd20)      return (b & c) | (~b & d);
    else if (t < 7'd40) return b ^ c ^ d;
    else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

  function automatic word_t sha1_k(input logic [6:0] t);
    if (t < 7'd20)      return K0;
    else if (t < 7'd40) return K1;
    else if (t < 7'd60) return K2;
    else                return K3;
  endfunction

endpackage

// File: rtl/sha1_round_ctrl_if.sv
// Register-interface bus between the SHA-1 register block (master) and the round controller (slave).
// Handshake: enable_hash_i is a one-cycle start accepted only while idle_o=1; digest_valid_o stays
// high until digest_ack_i is seen; reset_hash_i wins over both.
interface sha1_round_ctrl_if;
  logic         enable_hash_i;
  logic         reset_hash_i;
  logic [511:0] block_i;
  logic         digest_ack_i;
  logic         hold_o;
  logic         idle_o;
  logic [159:0] digest_o;
  logic         digest_valid_o;

  modport master (
    output enable_hash_i, reset_hash_i, block_i, digest_ack_i,
    input  hold_o, idle_o, digest_o, digest_valid_o
  );

  modport slave (
    input  enable_hash_i, reset_hash_i, block_i, digest_ack_i,
    output hold_o, idle_o, digest_o, digest_valid_o
  );
endinterface

// File: rtl/sha1_msg_schedule.sv
// 16-word rolling SHA-1 message schedule; w_o is the schedule word for round t_i.
module sha1_msg_schedule
  import sha1_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [511:0] block_i,
  input  logic         advance_i,
  input  logic [6:0]   t_i,
  output word_t        w_o
);

  word_t      w_q [16];
  logic [3:0] slot;

  assign slot = t_i[3:0];

  // Slot t mod 16 still holds W[t-16] until it is overwritten with W[t].
  always_comb begin
    w_o = w_q[slot];
    if (t_i >= 7'd16) begin
      w_o = rotl(w_q[slot - 4'd3] ^ w_q[slot - 4'd8] ^ w_q[slot - 4'd14] ^ w_q[slot], 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else if (load_i) begin
      for (int i = 0; i < 16; i++) w_q[i] <= block_i[511 - 32*i -: 32];
    end else if (advance_i && t_i >= 7'd16) begin
      w_q[slot] <= w_o;
    end
  end

endmodule

// File: rtl/sha1_round_ctrl.sv
// SHA-1 compression sequencer: 80 rounds at one per cycle, then folds into H0..H4 and holds the digest.
module sha1_round_ctrl
  import sha1_pkg::*;
#(
  parameter int BlockWidth  = 512,
  parameter int DigestWidth = 160
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  sha1_round_ctrl_if.slave bus,
  output sha1_state_e      state_o
);

  sha1_state_e state_q, state_d;
  logic [6:0]  t_q;
  word_t       a_q, b_q, c_q, d_q, e_q;
  word_t       h_q [5];
  word_t       w_t, temp;
  logic        load, advance;
  logic [BlockWidth-1:0]  block;
  logic [DigestWidth-1:0] digest;

  assign block   = bus.block_i;
  assign load    = (state_q == ST_IDLE) && bus.enable_hash_i && !bus.reset_hash_i;
  assign advance = (state_q == ST_ROUND) && !bus.reset_hash_i;

  sha1_msg_schedule u_sched (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (load),
    .block_i   (block),
    .advance_i (advance),
    .t_i       (t_q),
    .w_o       (w_t)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.reset_hash_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (bus.enable_hash_i) state_d = ST_ROUND;
        ST_ROUND:  if (t_q == 7'd79) state_d = ST_UPDATE;
        ST_UPDATE: state_d = ST_DONE;
        ST_DONE:   if (bus.digest_ack_i) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign temp = rotl(a_q, 5) + sha1_f(t_q, b_q, c_q, d_q) + e_q + sha1_k(t_q) + w_t;

  // H is only written by reset or UPDATE, so an aborted block never leaks partial results.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      t_q <= '0;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0; e_q <= '0;
      h_q[0] <= H0_INIT; h_q[1] <= H1_INIT; h_q[2] <= H2_INIT;
      h_q[3] <= H3_INIT; h_q[4] <= H4_INIT;
    end else if (bus.reset_hash_i) begin
      t_q <= '0;
      h_q[0] <= H0_INIT; h_q[1] <= H1_INIT; h_q[2] <= H2_INIT;
      h_q[3] <= H3_INIT; h_q[4] <= H4_INIT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.enable_hash_i) begin
            t_q <= '0;
            a_q <= h_q[0]; b_q <= h_q[1]; c_q <= h_q[2]; d_q <= h_q[3]; e_q <= h_q[4];
          end
        end
        ST_ROUND: begin
          a_q <= temp;
          b_q <= a_q;
          c_q <= rotl(b_q, 30);
          d_q <= c_q;
          e_q <= d_q;
          if (t_q != 7'd79) t_q <= t_q + 7'd1;
        end
        ST_UPDATE: begin
          h_q[0] <= h_q[0] + a_q;
          h_q[1] <= h_q[1] + b_q;
          h_q[2] <= h_q[2] + c_q;
          h_q[3] <= h_q[3] + d_q;
          h_q[4] <= h_q[4] + e_q;
        end
        default: ;
      endcase
    end
  end

  assign digest             = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};
  assign bus.digest_o       = digest;
  assign bus.idle_o         = (state_q == ST_IDLE);
  assign bus.hold_o         = (state_q == ST_ROUND) || (state_q == ST_UPDATE);
  assign bus.digest_valid_o = (state_q == ST_DONE);
  assign state_o            = state_q;

endmodule

// File: tb/tb_sha1_round_ctrl.sv
// Bench for sha1_round_ctrl: cycle-level behavioural model plus known-answer SHA-1 digests.
module tb_sha1_round_ctrl;

  localparam logic [159:0] IV = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;
  // Negedge samples after the enable edge until digest_valid_o is first seen (80 rounds + UPDATE).
  localparam int LAT = 81;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  sha1_round_ctrl_if bus ();
  sha1_pkg::sha1_state_e dbg_state;

  sha1_round_ctrl dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference SHA-1 compression ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 80; t++) w[t] = rl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    {a, b, c, d, e} = h;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = rl(a, 5) + f + e + k + w[t];
      e = d; d = c; c = rl(b, 30); b = a; a = tmp;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- cycle-level model ----------------
  // m_cnt: 0 idle, 1..80 rounds in flight, 81 folding, 82 digest held.
  int           m_cnt = 0;
  logic [159:0] m_h = IV;
  logic [159:0] m_pend = '0;

  always @(posedge clk) begin
    if (!rst_n || bus.reset_hash_i) begin
      m_cnt <= 0;
      m_h   <= IV;
    end else if (m_cnt == 0) begin
      if (bus.enable_hash_i) begin
        m_pend <= sha1_compress(m_h, bus.block_i);
        m_cnt  <= 1;
      end
    end else if (m_cnt <= 80) begin
      m_cnt <= m_cnt + 1;
    end else if (m_cnt == 81) begin
      m_h   <= m_pend;
      m_cnt <= 82;
    end else if (bus.digest_ack_i) begin
      m_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_idle",   bus.idle_o,         m_cnt == 0);
      check("cyc_hold",   bus.hold_o,         m_cnt >= 1 && m_cnt <= 81);
      check("cyc_valid",  bus.digest_valid_o, m_cnt == 82);
      check("cyc_digest", bus.digest_o,       m_h);
    end
  end

  // ---------------- scoreboard ----------------
  logic [159:0] exp_q [$];
  logic [159:0] chain_h = IV;

  // ---------------- driver tasks ----------------
  task automatic start_block(input logic [511:0] blk);
    @(negedge clk);
    bus.block_i       = blk;
    bus.enable_hash_i = 1'b1;
    @(negedge clk);
    bus.enable_hash_i = 1'b0;
  endtask

  task automatic pulse_reset_hash();
    @(negedge clk);
    bus.reset_hash_i = 1'b1;
    @(negedge clk);
    bus.reset_hash_i = 1'b0;
    chain_h = IV;
  endtask

  // Waits for digest_valid_o, scribbling on block_i mid-block; n = negedges waited, nh = hold samples.
  task automatic wait_valid(output int n, output int nh);
    n = 0;
    nh = 0;
    while (!bus.digest_valid_o && n < 300) begin
      if (bus.hold_o) nh++;
      if (n == 5) bus.block_i = {16{$urandom}};
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("valid_timeout", bus.digest_valid_o, 1);
  endtask

  task automatic sb_check(input string name);
    if (exp_q.size() > 0) check(name, bus.digest_o, exp_q.pop_front());
    else check("sb_underflow", exp_q.size(), 1);
  endtask

  task automatic do_ack(input int delay);
    repeat (delay) @(negedge clk);
    bus.digest_ack_i = 1'b1;
    @(negedge clk);
    bus.digest_ack_i = 1'b0;
  endtask

  task automatic run_block(input logic [511:0] blk, input bit chk_lat, input int ack_delay);
    int n, nh;
    exp_q.push_back(sha1_compress(chain_h, blk));
    chain_h = sha1_compress(chain_h, blk);
    start_block(blk);
    wait_valid(n, nh);
    if (chk_lat) begin
      check("latency_valid", n, LAT);
      check("hold_cycles", nh, 81);
    end
    sb_check("sb_digest");
    do_ack(ack_delay);
  endtask

  // ---------------- stimulus ----------------
  logic [511:0] blk_abc, blk_empty, blk_two1, blk_two2, blk_rnd;
  logic [159:0] dig_abc, dig_empty, dig_two;

  initial begin
    int n, nh;
    bus.enable_hash_i = 1'b0;
    bus.reset_hash_i  = 1'b0;
    bus.block_i       = '0;
    bus.digest_ack_i  = 1'b0;

    blk_abc   = {32'h61626380, 448'h0, 32'h00000018};
    blk_empty = {32'h80000000, 480'h0};
    blk_two1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blk_two2  = {480'h0, 32'h000001c0};
    dig_abc   = 160'hA9993E364706816ABA3E25717850C26C9CD0D89D;
    dig_empty = 160'hDA39A3EE5E6B4B0D3255BFEF95601890AFD80709;
    dig_two   = 160'h84983E441C3BD26EBAAE4AA1F95129E5E54670F1;

    // Pin the reference model to published digests.
    check("model_abc",   sha1_compress(IV, blk_abc), dig_abc);
    check("model_empty", sha1_compress(IV, blk_empty), dig_empty);
    check("model_two",   sha1_compress(sha1_compress(IV, blk_two1), blk_two2), dig_two);

    // Reset
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_idle",   bus.idle_o, 1);
    check("rst_hold",   bus.hold_o, 0);
    check("rst_valid",  bus.digest_valid_o, 0);
    check("rst_digest", bus.digest_o, 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0);
    chk_en = 1'b1;

    // "abc" with latency checks
    run_block(blk_abc, 1'b1, 0);
    check("abc_literal", m_h, dig_abc);
    check("abc_digest_after_ack", bus.digest_o, dig_abc);

    // Empty message
    pulse_reset_hash();
    run_block(blk_empty, 1'b1, 2);
    check("empty_digest", bus.digest_o, dig_empty);

    // Two blocks, enable held during DONE
    pulse_reset_hash();
    exp_q.push_back(sha1_compress(chain_h, blk_two1));
    chain_h = sha1_compress(chain_h, blk_two1);
    start_block(blk_two1);
    wait_valid(n, nh);
    sb_check("two_blk1");
    bus.block_i       = blk_two2;
    bus.enable_hash_i = 1'b1;
    repeat (3) @(negedge clk);
    check("done_ignores_en_valid", bus.digest_valid_o, 1);
    check("done_ignores_en_hold",  bus.hold_o, 0);
    bus.enable_hash_i = 1'b0;
    do_ack(0);
    run_block(blk_two2, 1'b1, 1);
    check("two_digest", bus.digest_o, dig_two);

    // Abort at round 40
    start_block(blk_abc);
    repeat (40) @(negedge clk);
    check("mid_block_digest", bus.digest_o, dig_two);
    check("mid_block_hold", bus.hold_o, 1);
    bus.reset_hash_i = 1'b1;
    @(negedge clk);
    bus.reset_hash_i = 1'b0;
    chain_h = IV;
    check("abort_idle",   bus.idle_o, 1);
    check("abort_valid",  bus.digest_valid_o, 0);
    check("abort_digest", bus.digest_o, IV);
    run_block(blk_abc, 1'b1, 0);
    check("abc_after_abort", bus.digest_o, dig_abc);

    // reset_hash and enable together in IDLE
    @(negedge clk);
    bus.block_i       = blk_abc;
    bus.enable_hash_i = 1'b1;
    bus.reset_hash_i  = 1'b1;
    @(negedge clk);
    bus.enable_hash_i = 1'b0;
    bus.reset_hash_i  = 1'b0;
    chain_h = IV;
    check("rst_en_idle", bus.idle_o, 1);
    check("rst_en_hold", bus.hold_o, 0);
    repeat (3) @(negedge clk);
    check("rst_en_still_idle", bus.idle_o, 1);
    check("rst_en_digest", bus.digest_o, IV);

    // Random chained blocks
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 16; i++) blk_rnd[511 - 32*i -: 32] = $urandom;
      run_block(blk_rnd, 1'b0, $urandom_range(0, 4));
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
